// File: rtl/booth_multiplier_if.sv
// Handshake and operand/result bundle between the control unit and the
// radix-4 Booth multiplier.
interface booth_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  hi,
    input  lo
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output hi,
    output lo
  );
endinterface

// File: rtl/booth_multiplier.sv
// Sequential signed multiplier: radix-4 Booth recoding, two multiplier bits
// retired per clock, full 2*WIDTH-bit product delivered as hi/lo.
module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               clr,
  booth_multiplier_if.slave bus
);

  localparam int AW = WIDTH + 2;
  localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    m_q, m_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic             q1_q, q1_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, done_q;
  logic [AW-1:0]    acc_sum_s;

  // Partial product for one Booth digit; the two guard bits keep -2M exact.
  function automatic logic [AW-1:0] booth_pp(input logic [2:0] sel,
                                             input logic [AW-1:0] m);
    logic [AW-1:0] m2;
    m2 = {m[AW-2:0], 1'b0};
    case (sel)
      3'b001, 3'b010: booth_pp = m;
      3'b011:         booth_pp = m2;
      3'b100:         booth_pp = (~m2) + AW'(1);
      3'b101, 3'b110: booth_pp = (~m) + AW'(1);
      default:        booth_pp = {AW{1'b0}};
    endcase
  endfunction

  // Next-state and datapath step
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    acc_d     = acc_q;
    qr_d      = qr_q;
    q1_d      = q1_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_sum_s = acc_q + booth_pp({qr_q[1:0], q1_q}, m_q);
    case (state_q)
      ST_RUN: begin
        acc_d = {{2{acc_sum_s[AW-1]}}, acc_sum_s[AW-1:2]};
        qr_d  = {acc_sum_s[1:0], qr_q[WIDTH-1:2]};
        q1_d  = qr_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          // Final step: the shifted acc low half and Q form the product.
          state_d = ST_DONE;
          cnt_d   = {CW{1'b0}};
          hi_d    = acc_sum_s[AW-1:2];
          lo_d    = {acc_sum_s[1:0], qr_q[WIDTH-1:2]};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          cnt_d   = {CW{1'b0}};
          m_d     = {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
          acc_d   = {AW{1'b0}};
          qr_d    = bus.multiplier;
          q1_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      m_q     <= {AW{1'b0}};
      acc_q   <= {AW{1'b0}};
      qr_q    <= {WIDTH{1'b0}};
      q1_q    <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      q1_q    <= q1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed self-checking bench for booth_multiplier (WIDTH=32).
module tb_booth_multiplier;

  logic clk;
  logic clr;
  int   checks;
  int   failures;
  int   lat;
  int   busy_cnt;
  int   done_seen;

  booth_multiplier_if #(.WIDTH(32)) bus ();

  booth_multiplier #(.WIDTH(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive operands with start for one edge; returns at the negedge after E0.
  task automatic start_op(input logic [31:0] m, input logic [31:0] q);
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start        = 1'b0;
  endtask

  // Counts negedges until done (bounded); busy_o samples include the current one.
  task automatic wait_done(output int cycles, output int busy_n);
    cycles = 0;
    busy_n = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (bus.busy === 1'b1 && bus.done !== 1'b1) busy_n++;
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    clr          = 1'b1;
    bus.start    = 1'b0;
    bus.multiplicand = 32'd0;
    bus.multiplier   = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    clr = 1'b0;
    @(negedge clk);

    // 1: 7 x -3, latency and busy length
    start_op(32'd7, 32'hFFFF_FFFD);
    wait_done(lat, busy_cnt);
    check("t1_latency", 64'(lat), 64'd16);
    check("t1_busy_cycles", 64'(busy_cnt), 64'd16);
    check("t1_product", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    check("t1_done_pulse", {63'd0, bus.done}, 64'd0);
    check("t1_hold", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // 2: most-negative squared (-2M guard-bit path)
    start_op(32'h8000_0000, 32'h8000_0000);
    wait_done(lat, busy_cnt);
    check("t2_product", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);

    // 3: largest positive squared, zero operand, most-negative x 1
    @(negedge clk);
    start_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_done(lat, busy_cnt);
    check("t3_maxpos", {bus.hi, bus.lo}, 64'h3FFF_FFFF_0000_0001);
    @(negedge clk);
    start_op(32'd0, 32'h1234_5678);
    wait_done(lat, busy_cnt);
    check("t3_zero", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    start_op(32'h8000_0000, 32'd1);
    wait_done(lat, busy_cnt);
    check("t3_minneg_x1", {bus.hi, bus.lo}, 64'hFFFF_FFFF_8000_0000);

    // 4: start and operand changes during RUN are ignored
    @(negedge clk);
    start_op(32'd5, 32'd6);
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd9;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start        = 1'b0;
    wait_done(lat, busy_cnt);
    check("t4_latency", 64'(lat), 64'd15);
    check("t4_product", {bus.hi, bus.lo}, 64'd30);
    @(negedge clk);
    check("t4_no_restart", {63'd0, bus.busy}, 64'd0);

    // 5: async clear mid-operation
    start_op(32'd100, 32'd100);
    repeat (8) @(negedge clk);
    #1 clr = 1'b1;
    #1;
    check("t5_clr_busy", {63'd0, bus.busy}, 64'd0);
    check("t5_clr_done", {63'd0, bus.done}, 64'd0);
    check("t5_clr_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    clr = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1;
    end
    check("t5_no_done_after_clr", 64'(done_seen), 64'd0);
    start_op(32'hFFFF_FFFC, 32'd5);
    wait_done(lat, busy_cnt);
    check("t5_product", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEC);

    // 6: back-to-back start during DONE
    @(negedge clk);
    start_op(32'd3, 32'd4);
    wait_done(lat, busy_cnt);
    check("t6_first", {bus.hi, bus.lo}, 64'd12);
    bus.multiplicand = 32'hFFFF_FFFF;
    bus.multiplier   = 32'hFFFF_FFFF;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start        = 1'b0;
    check("t6_no_idle_gap", {63'd0, bus.busy}, 64'd1);
    wait_done(lat, busy_cnt);
    check("t6_latency", 64'(lat), 64'd16);
    check("t6_product", {bus.hi, bus.lo}, 64'd1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
